// File: rtl/video_timing_gen_if.sv
// Raster output bundle from the timing generator to the TMDS encoders.
// master = timing generator, slave = downstream consumer.
interface video_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;
  logic [CNT_W-1:0] x_o;
  logic [CNT_W-1:0] y_o;
  logic             line_start_o;
  logic             frame_start_o;

  modport master (
    output hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );

  modport slave (
    input  hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates and line/frame strobes.
// Latency: outputs are the registered decode of the counters, one pixel clock behind them.
// Backpressure: none; en_i low holds counters at (0,0) and parks the outputs idle.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  video_timing_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries, sized to the counters so every compare is width-matched.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             de_d;
  logic             hs_d;
  logic             vs_d;
  logic             ls_d;
  logic             fs_d;

  // Decode the current counter position into next-cycle output values.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    de_d   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    // v_cnt only moves on the h wrap, so vsync naturally toggles at x=0.
    hs_d   = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    vs_d   = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    ls_d   = (h_cnt == '0) && (v_cnt < V_ACT);
    fs_d   = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters: free-run while enabled, snap back to (0,0) when disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Output register: all outputs move together so they stay mutually aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vid.hsync_o       <= ~HS_POL;
      vid.vsync_o       <= ~VS_POL;
      vid.de_o          <= 1'b0;
      vid.x_o           <= '0;
      vid.y_o           <= '0;
      vid.line_start_o  <= 1'b0;
      vid.frame_start_o <= 1'b0;
    end else if (!en_i) begin
      vid.hsync_o       <= ~HS_POL;
      vid.vsync_o       <= ~VS_POL;
      vid.de_o          <= 1'b0;
      vid.x_o           <= '0;
      vid.y_o           <= '0;
      vid.line_start_o  <= 1'b0;
      vid.frame_start_o <= 1'b0;
    end else begin
      vid.hsync_o       <= hs_d;
      vid.vsync_o       <= vs_d;
      vid.de_o          <= de_d;
      vid.x_o           <= h_cnt;
      vid.y_o           <= v_cnt;
      vid.line_start_o  <= ls_d;
      vid.frame_start_o <= fs_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (640x480 defaults, tiny active-high,
// mid-size active-low) share clock/reset/enable and are compared every cycle
// against an arithmetic raster model driven by cycles-since-enable.
module tb_video_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CNT_W(11)) vif_a ();
  video_timing_gen_if #(.CNT_W(11)) vif_b ();
  video_timing_gen_if #(.CNT_W(11)) vif_c ();

  video_timing_gen dut_a (
    .clk_i (clk), .rst_ni (rst_n), .en_i (en), .vid (vif_a)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
  ) dut_b (
    .clk_i (clk), .rst_ni (rst_n), .en_i (en), .vid (vif_b)
  );

  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11)
  ) dut_c (
    .clk_i (clk), .rst_ni (rst_n), .en_i (en), .vid (vif_c)
  );

  // Packed view: [26]hsync [25]vsync [24]de [23]line_start [22]frame_start [21:11]x [10:0]y
  logic [26:0] a_out, b_out, c_out;
  assign a_out = {vif_a.hsync_o, vif_a.vsync_o, vif_a.de_o, vif_a.line_start_o,
                  vif_a.frame_start_o, vif_a.x_o, vif_a.y_o};
  assign b_out = {vif_b.hsync_o, vif_b.vsync_o, vif_b.de_o, vif_b.line_start_o,
                  vif_b.frame_start_o, vif_b.x_o, vif_b.y_o};
  assign c_out = {vif_c.hsync_o, vif_c.vsync_o, vif_c.de_o, vif_c.line_start_o,
                  vif_c.frame_start_o, vif_c.x_o, vif_c.y_o};

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got hs%b vs%b de%b ls%b fs%b x=%0d y=%0d, want hs%b vs%b de%b ls%b fs%b x=%0d y=%0d",
               nm, $time, act[26], act[25], act[24], act[23], act[22], act[21:11], act[10:0],
               exp[26], exp[25], exp[24], exp[23], exp[22], exp[21:11], exp[10:0]);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Raster model: output k cycles after enable is pixel (k mod H_TOTAL, (k div H_TOTAL) mod V_TOTAL).
  function automatic logic [26:0] model(input bit vld, input int k,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp);
    int ht, vt, x, y;
    logic hsy, vsy, de, ls, fs;
    if (!vld) return {~hp, ~vp, 3'b000, 22'd0};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    x   = k % ht;
    y   = (k / ht) % vt;
    de  = (x < ha) && (y < va);
    hsy = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
    vsy = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
    ls  = (x == 0) && (y < va);
    fs  = (x == 0) && (y == 0);
    return {hsy, vsy, de, ls, fs, 11'(x), 11'(y)};
  endfunction

  // Model timebase: which output index (cycles since enable) each edge produces.
  bit out_vld = 1'b0;
  int n_cyc   = 0;
  int k_cur   = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        out_vld = 1'b0;
        n_cyc   = 0;
      end else if (en) begin
        k_cur   = n_cyc;
        n_cyc   = n_cyc + 1;
        out_vld = 1'b1;
      end else begin
        out_vld = 1'b0;
        n_cyc   = 0;
      end
    end
  end

  // Per-cycle compare plus aggregate counters for the first default-raster run.
  bit first_run = 1'b1;
  int a_de_cnt  = 0;
  int a_hs_cnt  = 0;
  int a_ls_cnt  = 0;
  int cyc       = 0;
  int last_fs_b = -1;
  int last_fs_c = -1;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("dut_a_model", a_out, model(out_vld, k_cur, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      check("dut_b_model", b_out, model(out_vld, k_cur, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1));
      check("dut_c_model", c_out, model(out_vld, k_cur, 20, 2, 4, 3, 10, 2, 2, 3, 1'b0, 1'b0));
      if (first_run && out_vld && k_cur < 2400) begin
        if (a_out[24])  a_de_cnt++;
        if (!a_out[26]) a_hs_cnt++;
        if (a_out[23])  a_ls_cnt++;
      end
      if (!out_vld) begin
        last_fs_b = -1;
        last_fs_c = -1;
      end else begin
        if (b_out[22]) begin
          if (last_fs_b >= 0) check_int("b_frame_period", cyc - last_fs_b, 48);
          last_fs_b = cyc;
        end
        if (c_out[22]) begin
          if (last_fs_c >= 0) check_int("c_frame_period", cyc - last_fs_c, 493);
          last_fs_c = cyc;
        end
      end
    end
  end

  initial begin
    bit hit;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset_idle", a_out, {1'b1, 1'b1, 3'b000, 22'd0});
    check("b_reset_idle", b_out, {1'b0, 1'b0, 3'b000, 22'd0});

    // Enable already high when reset releases: first edge emits pixel (0,0).
    en = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("a_first_pixel", a_out, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 22'd0});
    check("b_first_pixel", b_out, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'd0});

    // Three full 800-cycle lines of the default raster.
    repeat (2600) @(negedge clk);
    first_run = 1'b0;
    check_int("a_de_cycles_3_lines", a_de_cnt, 1920);
    check_int("a_hsync_low_3_lines", a_hs_cnt, 288);
    check_int("a_line_starts_3_lines", a_ls_cnt, 3);

    // Frame wrap on the tiny raster: (7,5) is followed by (0,0) with frame_start.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (vif_b.x_o == 11'd7) && (vif_b.y_o == 11'd5);
    end
    check_int("b_reach_last_pixel", int'(hit), 1);
    @(negedge clk);
    check("b_wrap_to_origin", b_out, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 22'd0});

    // Abort mid-frame on the mid-size raster, hold enable low for 5 edges.
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = (vif_c.x_o == 11'd7) && (vif_c.y_o == 11'd5);
    end
    check_int("c_reach_abort_point", int'(hit), 1);
    @(posedge clk);
    #2 en = 1'b0;
    repeat (5) @(posedge clk);
    #2 en = 1'b1;
    @(negedge clk);
    check("c_still_idle", c_out, {1'b1, 1'b1, 3'b000, 22'd0});
    @(posedge clk);
    @(negedge clk);
    check("c_restart_origin", c_out, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 22'd0});
    check("a_restart_origin", a_out, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 22'd0});

    // Random runs and enable drops.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 700)) @(posedge clk);
      #2 en = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #2 en = 1'b1;
    end
    repeat (600) @(posedge clk);

    // Asynchronous reset in the middle of a cycle clears outputs without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("a_async_reset", a_out, {1'b1, 1'b1, 3'b000, 22'd0});
    check("b_async_reset", b_out, {1'b0, 1'b0, 3'b000, 22'd0});
    check("c_async_reset", c_out, {1'b1, 1'b1, 3'b000, 22'd0});
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
